// File: rtl/j1_io_uart.sv
// j1_io_uart: memory-mapped 8N1 UART for the j1 CPU I/O bus.
// Registers (exact address match):
//   BASE+0 DATA   : write pushes a TX byte; read pops the RX head (0 if empty)
//   BASE+2 STATUS : {11'b0, frame_err, overrun, tx_idle, tx_full, rx_valid};
//                   any write clears frame_err and overrun
//   BASE+4 DIV    : clocks per bit, writes below 4 are stored as 4
// Ports:
//   sys_clk_i  - clock          sys_rst_i - synchronous active-low reset
//   io_addr    - CPU address    io_dout   - CPU write data
//   io_rd      - read strobe    io_wr     - write strobe
//   io_din     - read data (combinational, zero when not selected)
//   uart_rx_i  - async serial in   uart_tx_o - serial out, idles high
module j1_io_uart #(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter logic [15:0] CLK_DIV   = 16'd434,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  input  logic        io_rd,
  input  logic        io_wr,
  output logic [15:0] io_din,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);

  localparam int unsigned      DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      ADDR_DATA = BASE_ADDR;
  localparam logic [15:0]      ADDR_STAT = BASE_ADDR + 16'd2;
  localparam logic [15:0]      ADDR_DIV  = BASE_ADDR + 16'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic sel_data, sel_stat, sel_div;
  assign sel_data = (io_addr == ADDR_DATA);
  assign sel_stat = (io_addr == ADDR_STAT);
  assign sel_div  = (io_addr == ADDR_DIV);

  // Baud divisor register
  logic [15:0] div_q;
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i)            div_q <= CLK_DIV;
    else if (io_wr && sel_div) div_q <= (io_dout < 16'd4) ? 16'd4 : io_dout;
  end

  // TX FIFO
  logic [7:0]         txf_mem [DEPTH];
  logic [FIFO_AW-1:0] txf_wp_q, txf_rp_q;
  logic [FIFO_AW:0]   txf_cnt_q;
  logic               txf_full, txf_empty, txf_push, txf_pop;

  assign txf_full  = (txf_cnt_q == FULL_CNT);
  assign txf_empty = (txf_cnt_q == '0);
  assign txf_push  = io_wr & sel_data & ~txf_full;

  always_ff @(posedge sys_clk_i) begin
    if (txf_push) txf_mem[txf_wp_q] <= io_dout[7:0];
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      txf_wp_q  <= '0;
      txf_rp_q  <= '0;
      txf_cnt_q <= '0;
    end else begin
      if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
      if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
      if (txf_push && !txf_pop)      txf_cnt_q <= txf_cnt_q + 1'b1;
      else if (txf_pop && !txf_push) txf_cnt_q <= txf_cnt_q - 1'b1;
    end
  end

  // TX FSM
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        tx_idle;

  assign tx_idle = txf_empty & (tx_state_q == S_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txf_pop    = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!txf_empty) begin
          txf_pop    = 1'b1;
          tx_sh_d    = txf_mem[txf_rp_q];
          tx_div_d   = div_q;
          tx_cnt_d   = div_q - 16'd1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next frame so back-to-back bytes have no gap
          if (!txf_empty) begin
            txf_pop    = 1'b1;
            tx_sh_d    = txf_mem[txf_rp_q];
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= CLK_DIV;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx_o = tx_q;

  // RX synchronizer plus one extra flop for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX FIFO
  logic [7:0]         rxf_mem [DEPTH];
  logic [FIFO_AW-1:0] rxf_wp_q, rxf_rp_q;
  logic [FIFO_AW:0]   rxf_cnt_q;
  logic               rxf_full, rxf_empty, rxf_push, rxf_pop;
  logic               rx_done, rx_bad;

  assign rxf_full  = (rxf_cnt_q == FULL_CNT);
  assign rxf_empty = (rxf_cnt_q == '0);
  assign rxf_push  = rx_done & ~rxf_full;
  assign rxf_pop   = io_rd & sel_data & ~rxf_empty;

  // RX FSM
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;

  always_ff @(posedge sys_clk_i) begin
    if (rxf_push) rxf_mem[rxf_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      rxf_wp_q  <= '0;
      rxf_rp_q  <= '0;
      rxf_cnt_q <= '0;
    end else begin
      if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
      if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
      if (rxf_push && !rxf_pop)      rxf_cnt_q <= rxf_cnt_q + 1'b1;
      else if (rxf_pop && !rxf_push) rxf_cnt_q <= rxf_cnt_q - 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          // Half-bit wait puts every later sample near the bit centre
          rx_div_d   = div_q;
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_cnt_d   = rx_div_q - 16'd1;
            rx_bit_d   = '0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = rx_div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (rx_sync_q) rx_done = 1'b1;
          else           rx_bad  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= CLK_DIV;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear wins
  logic ovr_q, ferr_q;
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (io_wr && sel_stat) begin
        ovr_q  <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (rx_done && rxf_full) ovr_q  <= 1'b1;
      if (rx_bad)              ferr_q <= 1'b1;
    end
  end

  always_comb begin
    io_din = '0;
    if (io_rd) begin
      if (sel_data)      io_din = {8'h00, rxf_empty ? 8'h00 : rxf_mem[rxf_rp_q]};
      else if (sel_stat) io_din = {11'b0, ferr_q, ovr_q, tx_idle, txf_full, ~rxf_empty};
      else if (sel_div)  io_din = div_q;
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Testbench for j1_io_uart: scoreboard of expected bus reads and expected
// serial line levels, both produced by a behavioural model of the UART.
module tb_j1_io_uart;

  localparam logic [15:0] BASE = 16'hF000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] io_addr, io_dout, io_din;
  logic        io_rd, io_wr;
  logic        rx_drv, loop_en, rx_line, tx;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  j1_io_uart #(.BASE_ADDR(16'hF000), .CLK_DIV(16'd8), .FIFO_AW(3)) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_din   (io_din),
    .uart_rx_i(rx_line),
    .uart_tx_o(tx)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  bit          mon_en   = 1'b0;
  bit          lvl_q[$];            // expected uart_tx_o, one entry per clock
  logic [15:0] rd_exp_q[$];
  string       rd_nm_q[$];
  logic [7:0]  rx_m[$];             // model of RX FIFO contents
  bit          ovr_m, ferr_m;
  int unsigned div_m;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bytes waiting in the TX FIFO, derived from the outstanding line levels:
  // the frame on the wire owns 1..10*div levels, each queued byte a full frame.
  function automatic int unsigned tx_cnt_m();
    int unsigned l;
    l = lvl_q.size();
    return (l == 0) ? 0 : (l - 1) / (10 * div_m);
  endfunction

  function automatic logic [15:0] status_m();
    return {11'b0, ferr_m, ovr_m, (lvl_q.size() == 0), (tx_cnt_m() == 8), (rx_m.size() != 0)};
  endfunction

  task automatic push_frame(input logic [7:0] b);
    bit l;
    if (lvl_q.size() == 0) lvl_q.push_back(1'b1);  // one idle clock before the FSM pops
    for (int i = 0; i < 10; i++) begin
      l = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      repeat (div_m) lvl_q.push_back(l);
    end
  endtask

  task automatic rx_model_push(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)              ferr_m = 1'b1;
    else if (rx_m.size() < 8)  rx_m.push_back(b);
    else                       ovr_m = 1'b1;
  endtask

  // kind: 0 DATA, 1 STATUS, 2 DIV, other = unmapped address
  task automatic rd(input int kind, input string nm);
    logic [15:0] e;
    @(posedge clk); #1;
    e = '0;
    case (kind)
      0: begin io_addr = BASE; if (rx_m.size() > 0) e = {8'h00, rx_m.pop_front()}; end
      1: begin io_addr = BASE + 16'd2; e = status_m(); end
      2: begin io_addr = BASE + 16'd4; e = 16'(div_m); end
      default: io_addr = BASE + 16'd6;
    endcase
    io_rd = 1'b1;
    rd_exp_q.push_back(e);
    rd_nm_q.push_back(nm);
    @(posedge clk); #1;
    io_rd   = 1'b0;
    io_addr = '0;
  endtask

  task automatic wr(input int kind, input logic [15:0] d);
    bit acc;
    @(posedge clk); #1;
    io_addr = (kind == 0) ? BASE : (kind == 1) ? BASE + 16'd2 : BASE + 16'd4;
    io_dout = d;
    io_wr   = 1'b1;
    acc     = (kind == 0) && (tx_cnt_m() < 8);
    @(posedge clk); #1;
    io_wr   = 1'b0;
    io_addr = '0;
    if (acc) push_frame(d[7:0]);
    if (kind == 1) begin ovr_m = 1'b0; ferr_m = 1'b0; end
    if (kind == 2) div_m = (d < 16'd4) ? 4 : int'(d);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (div_m) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    rx_model_push(b, stop_ok);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_tx_done(input string nm);
    int n;
    n = 0;
    while (lvl_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (lvl_q.size() > 0) begin
      n_errs++;
      $display("FAIL %s: %0d line levels still pending, required 0", nm, lvl_q.size());
    end
  endtask

  // Serial line monitor: compares every clock against the expected level stream
  always @(negedge clk) begin
    bit e;
    if (mon_en) begin
      if (lvl_q.size() > 0) begin
        e = lvl_q.pop_front();
        chk("tx_line", {15'b0, tx}, {15'b0, e});
      end else begin
        chk("tx_idle_line", {15'b0, tx}, 16'h0001);
      end
    end
  end

  // Bus read monitor
  always @(negedge clk) begin
    if (io_rd) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL rd_unexpected: got %h with no expected read queued", io_din);
      end else begin
        chk(rd_nm_q.pop_front(), io_din, rd_exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    rst_n = 1'b0; io_addr = '0; io_dout = '0; io_rd = 1'b0; io_wr = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; div_m = 8; ovr_m = 1'b0; ferr_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset values
    chk("rst_tx", {15'b0, tx}, 16'h0001);
    @(negedge clk);
    io_addr = BASE;
    #1 chk("din_no_rd", io_din, 16'h0000);
    io_addr = '0;
    rd(1, "rst_status");
    rd(2, "rst_div");
    rd(0, "rst_data");
    rd(3, "unmapped");

    // Single TX frame
    wr(0, 16'h00A5);
    wait_tx_done("tx_a5_done");
    rd(1, "tx_done_status");

    // Loopback, back-to-back frames
    loop_en = 1'b1;
    wr(0, 16'h0031);
    wr(0, 16'h0032);
    wr(0, 16'h0033);
    wait_tx_done("loop_done");
    repeat (5) @(posedge clk);
    loop_en = 1'b0;
    rx_model_push(8'h31, 1'b1);
    rx_model_push(8'h32, 1'b1);
    rx_model_push(8'h33, 1'b1);
    for (int i = 0; i < 4; i++) rd(0, "loop_data");

    // TX FIFO overflow with transmitter busy
    wr(0, 16'($urandom_range(0, 255)));
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      wr(0, 16'($urandom_range(0, 255)));
      if (i == 7) rd(1, "tx_full_status");
    end
    wait_tx_done("tx_ovf_done");

    // RX overflow
    for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
    rd(1, "rx_ovr_status");
    for (int i = 0; i < 9; i++) rd(0, "rx_ovr_data");
    wr(1, 16'h0000);
    rd(1, "ovr_cleared");

    // Framing error
    send_rx(8'($urandom), 1'b0);
    rd(1, "ferr_status");
    rd(0, "ferr_data");
    wr(1, 16'hFFFF);
    rd(1, "ferr_cleared");

    // Short low glitch must not start a frame
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    rd(1, "glitch_status");
    rd(0, "glitch_data");

    // Random RX traffic with occasional bad stop bits
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_rx(b, ok);
      case ($urandom_range(0, 2))
        0: rd(0, "rnd_data");
        1: rd(1, "rnd_status");
        default: ;
      endcase
    end
    for (int k = 0; k < 9 && rx_m.size() > 0; k++) rd(0, "drain_data");
    rd(0, "drain_empty");
    wr(1, 16'h0000);
    rd(1, "rnd_status_clr");

    // Random TX traffic with random gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 100)) @(posedge clk);
      wr(0, 16'($urandom));
    end
    wait_tx_done("rnd_tx_done");

    // Divisor clamp and a frame at a non-default divisor
    wr(2, 16'd2);      rd(2, "div_clamp2");
    wr(2, 16'd3);      rd(2, "div_clamp3");
    wr(2, 16'd0);      rd(2, "div_clamp0");
    wr(2, 16'h0123);   rd(2, "div_0123");
    wr(2, 16'd5);      rd(2, "div_5");
    wr(0, 16'($urandom_range(0, 255)));
    wait_tx_done("div5_done");
    wr(2, 16'd8);      rd(2, "div_8");

    // Reset in the middle of a data bit with bytes still queued
    wr(0, 16'h005A);
    wr(0, 16'h0011);
    wr(0, 16'h0022);
    repeat (20) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", {15'b0, tx}, 16'h0001);
    lvl_q.delete();
    rx_m.delete();
    ovr_m = 1'b0; ferr_m = 1'b0; div_m = 8;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    rd(1, "midrst_status");
    rd(2, "midrst_div");
    repeat (150) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
